aabb_collision_scanner: RTL and testbench

- Sequential all-pairs AABB collision engine over a register table of NUM_OBJECTS boxes. Sprites, player and projectiles share the table.
- Software or the sprite engine loads boxes while idle, then pulses start.
- The block tests one unique pair (i<j) per clock and reports a per-object hit mask, a hit count and the first colliding pair.
- Sits beside the sprite engine. Typically started once per frame at vblank.

---
 rtl/aabb_collision_scanner.sv | 168 ++++++++++++++++
 tb/tb_aabb_collision_scanner.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aabb_collision_scanner.sv
// All-pairs AABB collision scanner: tests one unique pair (i<j) per clock over a register table of boxes.
// Optional macro AABB_TOUCH_INCLUSIVE_EN makes edge/corner contact count as overlap.
module aabb_collision_scanner #(
  parameter int POSITION_REG_MAX = 11,
  parameter int NUM_OBJECTS      = 8,
  parameter int IDX_W            = $clog2(NUM_OBJECTS),
  parameter int CNT_W            = $clog2(NUM_OBJECTS*(NUM_OBJECTS-1)/2+1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [IDX_W-1:0]          wr_idx,
  input  logic                      wr_valid,
  input  logic [POSITION_REG_MAX:0] wr_x1,
  input  logic [POSITION_REG_MAX:0] wr_y1,
  input  logic [POSITION_REG_MAX:0] wr_x2,
  input  logic [POSITION_REG_MAX:0] wr_y2,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [NUM_OBJECTS-1:0]    hit_mask,
  output logic [CNT_W-1:0]          hit_count,
  output logic                      first_valid,
  output logic [IDX_W-1:0]          first_a,
  output logic [IDX_W-1:0]          first_b
);

  localparam int POS_W = POSITION_REG_MAX + 1;
  localparam logic [IDX_W-1:0] LAST_I   = IDX_W'(NUM_OBJECTS - 2);
  localparam logic [IDX_W-1:0] LAST_J   = IDX_W'(NUM_OBJECTS - 1);
  localparam logic [IDX_W:0]   NUM_OBJ_X = (IDX_W+1)'(NUM_OBJECTS);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                              state_q, state_d;
  logic [IDX_W-1:0]                    i_q, i_d, j_q, j_d;
  logic [NUM_OBJECTS-1:0]              valid_q, valid_d;
  logic [NUM_OBJECTS-1:0][POS_W-1:0]   x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
  logic [NUM_OBJECTS-1:0]              hit_mask_q, hit_mask_d;
  logic [CNT_W-1:0]                    hit_count_q, hit_count_d;
  logic                                first_valid_q, first_valid_d;
  logic [IDX_W-1:0]                    first_a_q, first_a_d, first_b_q, first_b_d;

  logic             idx_ok;
  logic             pair_hit;
  logic [POS_W-1:0] ax1, ay1, ax2, ay2, bx1, by1, bx2, by2;

  assign idx_ok = ({1'b0, wr_idx} < NUM_OBJ_X);

  always_comb begin
    ax1 = x1_q[i_q];
    ay1 = y1_q[i_q];
    ax2 = x2_q[i_q];
    ay2 = y2_q[i_q];
    bx1 = x1_q[j_q];
    by1 = y1_q[j_q];
    bx2 = x2_q[j_q];
    by2 = y2_q[j_q];
`ifdef AABB_TOUCH_INCLUSIVE_EN
    pair_hit = valid_q[i_q] && valid_q[j_q] &&
               (ax1 <= bx2) && (ax2 >= bx1) && (ay1 <= by2) && (ay2 >= by1);
`else
    pair_hit = valid_q[i_q] && valid_q[j_q] &&
               (ax1 < bx2) && (ax2 > bx1) && (ay1 < by2) && (ay2 > by1);
`endif
  end

  always_comb begin
    state_d       = state_q;
    i_d           = i_q;
    j_d           = j_q;
    valid_d       = valid_q;
    x1_d          = x1_q;
    y1_d          = y1_q;
    x2_d          = x2_q;
    y2_d          = y2_q;
    hit_mask_d    = hit_mask_q;
    hit_count_d   = hit_count_q;
    first_valid_d = first_valid_q;
    first_a_d     = first_a_q;
    first_b_d     = first_b_q;
    case (state_q)
      IDLE: begin
        // The table only accepts writes here, so a running scan sees a frozen snapshot.
        if (wr_en && idx_ok) begin
          valid_d[wr_idx] = wr_valid;
          x1_d[wr_idx]    = wr_x1;
          y1_d[wr_idx]    = wr_y1;
          x2_d[wr_idx]    = wr_x2;
          y2_d[wr_idx]    = wr_y2;
        end
        if (start) begin
          state_d       = SCAN;
          i_d           = '0;
          j_d           = IDX_W'(1);
          hit_mask_d    = '0;
          hit_count_d   = '0;
          first_valid_d = 1'b0;
          first_a_d     = '0;
          first_b_d     = '0;
        end
      end
      SCAN: begin
        if (pair_hit) begin
          hit_mask_d[i_q] = 1'b1;
          hit_mask_d[j_q] = 1'b1;
          hit_count_d     = hit_count_q + CNT_W'(1);
          if (!first_valid_q) begin
            first_valid_d = 1'b1;
            first_a_d     = i_q;
            first_b_d     = j_q;
          end
        end
        if (i_q == LAST_I && j_q == LAST_J) begin
          state_d = DONE;
        end else if (j_q == LAST_J) begin
          i_d = i_q + IDX_W'(1);
          j_d = i_q + IDX_W'(2);
        end else begin
          j_d = j_q + IDX_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      i_q           <= '0;
      j_q           <= '0;
      valid_q       <= '0;
      x1_q          <= '0;
      y1_q          <= '0;
      x2_q          <= '0;
      y2_q          <= '0;
      hit_mask_q    <= '0;
      hit_count_q   <= '0;
      first_valid_q <= 1'b0;
      first_a_q     <= '0;
      first_b_q     <= '0;
    end else begin
      state_q       <= state_d;
      i_q           <= i_d;
      j_q           <= j_d;
      valid_q       <= valid_d;
      x1_q          <= x1_d;
      y1_q          <= y1_d;
      x2_q          <= x2_d;
      y2_q          <= y2_d;
      hit_mask_q    <= hit_mask_d;
      hit_count_q   <= hit_count_d;
      first_valid_q <= first_valid_d;
      first_a_q     <= first_a_d;
      first_b_q     <= first_b_d;
    end
  end

  assign busy        = (state_q == SCAN);
  assign done        = (state_q == DONE);
  assign hit_mask    = hit_mask_q;
  assign hit_count   = hit_count_q;
  assign first_valid = first_valid_q;
  assign first_a     = first_a_q;
  assign first_b     = first_b_q;

endmodule

// File: tb/tb_aabb_collision_scanner.sv
// Scoreboard bench for aabb_collision_scanner: a pair-loop reference model predicts each scan's results.
module tb_aabb_collision_scanner;

  localparam int N      = 8;
  localparam int PW     = 12;
  localparam int IW     = 3;
  localparam int CW     = 5;
  localparam int NPAIRS = N*(N-1)/2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [IW-1:0] wr_idx = '0;
  logic          wr_valid = 1'b0;
  logic [PW-1:0] wr_x1 = '0, wr_y1 = '0, wr_x2 = '0, wr_y2 = '0;
  logic          start = 1'b0;
  logic          busy, done, first_valid;
  logic [N-1:0]  hit_mask;
  logic [CW-1:0] hit_count;
  logic [IW-1:0] first_a, first_b;

  aabb_collision_scanner #(.POSITION_REG_MAX(PW-1), .NUM_OBJECTS(N)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_valid(wr_valid),
    .wr_x1(wr_x1), .wr_y1(wr_y1), .wr_x2(wr_x2), .wr_y2(wr_y2), .start(start),
    .busy(busy), .done(done), .hit_mask(hit_mask), .hit_count(hit_count),
    .first_valid(first_valid), .first_a(first_a), .first_b(first_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [N-1:0] mask;
    int cnt;
    int fv;
    int a;
    int b;
    int sc;
  } exp_t;

  exp_t sb[$];

  // Reference table
  bit mv[N];
  int mx1[N], my1[N], mx2[N], my2[N];

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  function automatic bit boxes_overlap(input int a, input int b);
    if (!mv[a] || !mv[b]) return 1'b0;
`ifdef AABB_TOUCH_INCLUSIVE_EN
    return (mx1[a] <= mx2[b]) && (mx2[a] >= mx1[b]) && (my1[a] <= my2[b]) && (my2[a] >= my1[b]);
`else
    return (mx1[a] < mx2[b]) && (mx2[a] > mx1[b]) && (my1[a] < my2[b]) && (my2[a] > my1[b]);
`endif
  endfunction

  function automatic exp_t model_scan();
    exp_t e;
    e.mask = '0; e.cnt = 0; e.fv = 0; e.a = 0; e.b = 0; e.sc = 0;
    for (int i = 0; i < N; i++)
      for (int j = i + 1; j < N; j++)
        if (boxes_overlap(i, j)) begin
          e.mask[i] = 1'b1;
          e.mask[j] = 1'b1;
          e.cnt++;
          if (e.fv == 0) begin e.fv = 1; e.a = i; e.b = j; end
        end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest pending prediction.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hit_mask", hit_mask, e.mask);
        chk("hit_count", hit_count, e.cnt);
        chk("first_valid", first_valid, e.fv);
        chk("first_a", first_a, e.a);
        chk("first_b", first_b, e.b);
        chk("done_cycle", cyc - e.sc + 1, NPAIRS + 1);
        chk("busy_in_done", busy, 0);
      end
    end
  end

  task automatic drive_wr(input int idx, input bit v, input int x1, input int y1, input int x2, input int y2);
    wr_en = 1'b1; wr_idx = IW'(idx); wr_valid = v;
    wr_x1 = PW'(x1); wr_y1 = PW'(y1); wr_x2 = PW'(x2); wr_y2 = PW'(y2);
  endtask

  task automatic model_wr(input int idx, input bit v, input int x1, input int y1, input int x2, input int y2);
    mv[idx] = v; mx1[idx] = x1; my1[idx] = y1; mx2[idx] = x2; my2[idx] = y2;
  endtask

  task automatic wr(input int idx, input bit v, input int x1, input int y1, input int x2, input int y2);
    drive_wr(idx, v, x1, y1, x2, y2);
    model_wr(idx, v, x1, y1, x2, y2);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic clear_table();
    for (int k = 0; k < N; k++) wr(k, 1'b0, 0, 0, 0, 0);
  endtask

  // Issue start; a write already driven on wr_* lands in the same edge.
  task automatic do_start();
    exp_t e;
    e = model_scan();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wr_en = 1'b0;
    e.sc = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(posedge clk);
    if (sb.size() != 0) begin
      chk("done_timeout", sb.size(), 0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic scan();
    do_start();
    wait_done();
  endtask

  initial begin
    for (int k = 0; k < N; k++) model_wr(k, 1'b0, 0, 0, 0, 0);
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hit_mask", hit_mask, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_first_valid", first_valid, 0);
    chk("rst_first_a", first_a, 0);
    chk("rst_first_b", first_b, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Every box identical: all 28 pairs hit
    for (int k = 0; k < N; k++) wr(k, 1'b1, 0, 0, 8, 8);
    scan();
    chk("hold_hit_count", hit_count, NPAIRS);

    // Reset mid-scan aborts without a done pulse
    do_start();
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    for (int k = 0; k < N; k++) model_wr(k, 1'b0, 0, 0, 0, 0);
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_hit_mask", hit_mask, 0);
    chk("midrst_hit_count", hit_count, 0);
    chk("midrst_first_valid", first_valid, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    scan();

    // Single overlapping pair
    wr(0, 1'b1, 10, 10, 20, 20);
    wr(3, 1'b1, 15, 15, 30, 30);
    scan();

    // Shared vertical edge
    clear_table();
    wr(1, 1'b1, 0, 0, 16, 16);
    wr(2, 1'b1, 16, 0, 32, 16);
    scan();

    // Validity gating
    clear_table();
    wr(4, 1'b1, 0, 0, 10, 10);
    wr(5, 1'b0, 5, 5, 15, 15);
    scan();

    // Busy lockout: write and restart attempts during SCAN are ignored
    clear_table();
    wr(0, 1'b1, 0, 0, 10, 10);
    wr(1, 1'b1, 5, 5, 20, 20);
    wr(6, 1'b1, 18, 18, 40, 40);
    do_start();
    repeat (3) @(posedge clk);
    #1;
    drive_wr(0, 1'b1, 4000, 4000, 4095, 4095);
    start = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0; start = 1'b0;
    wait_done();
    repeat (3) @(posedge clk);
    #1;
    scan();

    // Write and start in the same cycle: the scan must see the write
    clear_table();
    wr(2, 1'b1, 100, 100, 120, 120);
    drive_wr(7, 1'b1, 110, 90, 130, 105);
    model_wr(7, 1'b1, 110, 90, 130, 105);
    do_start();
    wait_done();

    // Randomized tables, including degenerate boxes
    for (int t = 0; t < 20; t++) begin
      for (int k = 0; k < N; k++) begin
        int x1, y1, x2, y2;
        x1 = $urandom_range(0, 63);
        y1 = $urandom_range(0, 63);
        x2 = x1 + $urandom_range(0, 24) - 2;
        y2 = y1 + $urandom_range(0, 24) - 2;
        if (x2 < 0) x2 = 0;
        if (y2 < 0) y2 = 0;
        wr(k, ($urandom_range(0, 9) < 8), x1, y1, x2, y2);
      end
      scan();
    end

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
